// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx #(
  parameter int CLOCK_FREQ_HZ = 25_000_000,
  parameter int BAUD_RATE     = 9_600,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_BIT    = 0,
  parameter int ODD_PARITY    = 1,
  parameter int STOP_BITS     = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_break,
`endif
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BIT_CYCLES = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int CYC_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W      = $clog2(DATA_BITS);

  localparam logic [CYC_W-1:0] CYC_LOAD  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_ZERO  = CYC_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO  = BIT_W'(0);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5,
    S_MARK   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`endif

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (ODD_PARITY != 0);
  endfunction

  state_t               r_state, w_state_nxt;
  logic [DATA_BITS:0]   r_shift, w_shift_nxt;
  logic [BIT_W-1:0]     r_bit,   w_bit_nxt;
  logic [CYC_W-1:0]     r_cyc,   w_cyc_nxt;
  logic                 r_tx,    w_tx_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_busy,  w_busy_nxt;
  logic                 r_done,  w_done_nxt;

  logic w_bit_end;
  logic w_last_stop;
  logic w_accept;

  assign w_bit_end   = (r_cyc == CYC_ZERO);
  assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit == STOP_LAST);

  // The shift register carries the parity bit above the data so it falls out after the last data bit.
`ifdef UART_TX_BREAK_EN
  assign w_accept = i_valid && !i_break && (r_ready || w_last_stop);
`else
  assign w_accept = i_valid && (r_ready || w_last_stop);
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_cyc_nxt   = r_cyc;
    w_tx_nxt    = r_tx;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (i_break) begin
          w_state_nxt = S_BREAK;
          w_tx_nxt    = 1'b0;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end else
`endif
        if (w_accept) begin
          w_state_nxt = S_START;
          w_shift_nxt = {parity_of(i_data), i_data};
          w_bit_nxt   = BIT_ZERO;
          w_cyc_nxt   = CYC_LOAD;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_ready_nxt = 1'b0;
        end else begin
          w_tx_nxt    = 1'b1;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_cyc_nxt   = CYC_LOAD;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cyc_nxt   = r_cyc - CYC_ONE;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cyc_nxt   = CYC_LOAD;
          w_shift_nxt = {1'b1, r_shift[DATA_BITS:1]};
          if (r_bit == DATA_LAST) begin
            w_bit_nxt = BIT_ZERO;
            if (PARITY_BIT != 0) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_shift[1];
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit + BIT_ONE;
            w_tx_nxt  = r_shift[1];
          end
        end else begin
          w_cyc_nxt = r_cyc - CYC_ONE;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_cyc_nxt   = CYC_LOAD;
          w_bit_nxt   = BIT_ZERO;
          w_tx_nxt    = 1'b1;
        end else begin
          w_cyc_nxt   = r_cyc - CYC_ONE;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit == STOP_LAST) begin
            w_done_nxt = 1'b1;
            // A word waiting at the end of the frame starts the next one with no idle gap.
            if (w_accept) begin
              w_state_nxt = S_START;
              w_shift_nxt = {parity_of(i_data), i_data};
              w_bit_nxt   = BIT_ZERO;
              w_cyc_nxt   = CYC_LOAD;
              w_tx_nxt    = 1'b0;
              w_busy_nxt  = 1'b1;
              w_ready_nxt = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_tx_nxt    = 1'b1;
              w_ready_nxt = 1'b1;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_bit_nxt = r_bit + BIT_ONE;
            w_cyc_nxt = CYC_LOAD;
          end
        end else begin
          w_cyc_nxt = r_cyc - CYC_ONE;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (!i_break) begin
          w_state_nxt = S_MARK;
          w_tx_nxt    = 1'b1;
          w_cyc_nxt   = CYC_LOAD;
        end else begin
          w_tx_nxt    = 1'b0;
        end
      end
      S_MARK: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cyc_nxt   = r_cyc - CYC_ONE;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
      r_shift <= {(DATA_BITS+1){1'b0}};
      r_bit   <= BIT_ZERO;
      r_cyc   <= CYC_ZERO;
      r_tx    <= 1'b1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_cyc   <= w_cyc_nxt;
      r_tx    <= w_tx_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_tx    = r_tx;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule
